// File: rtl/queen_pkg.sv
// Shared types and sizing for the N-queens solver and its board checker.
package queen_pkg;

  localparam int unsigned N      = 8;
  localparam int unsigned ROW_W  = $clog2(N);
  localparam int unsigned DIAG_N = 2 * N - 1;
  localparam int unsigned DIAG_W = $clog2(DIAG_N) + 1;
  localparam int unsigned ERR_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CHECK
  } state_e;

  typedef enum logic [ERR_W-1:0] {
    ERR_NONE    = 3'd0,
    ERR_ONEHOT  = 3'd1,
    ERR_ROW     = 3'd2,
    ERR_DIAG_DN = 3'd3,
    ERR_DIAG_UP = 3'd4
  } err_e;

endpackage

// File: rtl/queen_col_decode.sv
// Combinational column decode: one-hot legality and the row index of the queen.
module queen_col_decode
  import queen_pkg::*;
(
  input  logic [N-1:0]     col,
  output logic             onehot_ok,
  output logic [ROW_W-1:0] row
);

  always_comb begin
    onehot_ok = (col != '0) && ((col & (col - N'(1))) == '0);
    row       = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (col[i]) row = ROW_W'(i);
    end
  end

endmodule

// File: rtl/queen_board_checker.sv
// Sequential N-queens board validator: snapshots a board, checks one column per clock,
// reports verdict, first offending column and cause.
module queen_board_checker
  import queen_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               START,
  input  logic [N*N-1:0]     board,
  output logic               READY,
  output logic               BUSY,
  output logic               VALID,
  output logic [ERR_W-1:0]   ERR_CODE,
  output logic [ROW_W-1:0]   ERR_COL
);

  state_e              state_q, state_d;
  logic [N*N-1:0]      snap;
  logic [N-1:0]        rowmask;
  logic [DIAG_N-1:0]   dnmask, upmask;
  logic [ROW_W-1:0]    c;
  logic                valid_q;
  err_e                err_code_q;
  logic [ROW_W-1:0]    err_col_q;

  logic [N-1:0]        col;
  logic                onehot_ok;
  logic [ROW_W-1:0]    row;
  logic [DIAG_W-1:0]   dn_idx, up_idx;
  logic [DIAG_N-1:0]   dn_sel, up_sel;
  err_e                err;
  logic                last_col;

  assign col = snap[c*N +: N];

  queen_col_decode u_decode (
    .col       (col),
    .onehot_ok (onehot_ok),
    .row       (row)
  );

  // Diagonal masks are selected by shift rather than indexing, keeping the
  // wider no-wrap index width clean against the 2N-1 entry masks.
  always_comb begin
    dn_idx   = DIAG_W'(row) - DIAG_W'(c) + DIAG_W'(N - 1);
    up_idx   = DIAG_W'(row) + DIAG_W'(c);
    dn_sel   = DIAG_N'(1) << dn_idx;
    up_sel   = DIAG_N'(1) << up_idx;
    last_col = (c == ROW_W'(N - 1));
    err      = ERR_NONE;
    if (!onehot_ok)                err = ERR_ONEHOT;
    else if ((rowmask & col) != '0) err = ERR_ROW;
    else if ((dnmask & dn_sel) != '0) err = ERR_DIAG_DN;
    else if ((upmask & up_sel) != '0) err = ERR_DIAG_UP;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = CAPTURE;
      CAPTURE: if (!START) state_d = CHECK;
      CHECK:   if (err != ERR_NONE || last_col) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap       <= '0;
      rowmask    <= '0;
      dnmask     <= '0;
      upmask     <= '0;
      c          <= '0;
      valid_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      err_col_q  <= '0;
    end else begin
      case (state_q)
        CAPTURE: begin
          snap       <= board;
          rowmask    <= '0;
          dnmask     <= '0;
          upmask     <= '0;
          c          <= '0;
          valid_q    <= 1'b0;
          err_code_q <= ERR_NONE;
          err_col_q  <= '0;
        end
        CHECK: begin
          if (err != ERR_NONE) begin
            err_code_q <= err;
            err_col_q  <= c;
            valid_q    <= 1'b0;
          end else begin
            rowmask <= rowmask | col;
            dnmask  <= dnmask | dn_sel;
            upmask  <= upmask | up_sel;
            if (last_col) begin
              valid_q    <= 1'b1;
              err_code_q <= ERR_NONE;
              err_col_q  <= c;
            end else begin
              c <= c + ROW_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign READY    = (state_q == IDLE);
  assign BUSY     = (state_q != IDLE);
  assign VALID    = valid_q;
  assign ERR_CODE = err_code_q;
  assign ERR_COL  = err_col_q;

endmodule
